// File: rtl/pad_memory_responder.sv
// Target-side pad responder: word-organised data memory with a latched address and a prefetch register.
// A read is answered combinationally from the prefetch word. A write merges byte lanes into both the RAM and the prefetch word.
module pad_memory_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pad_write_address,
    input  logic [31:0] pad_address,
    input  logic [1:0]  pad_data_size,
    input  logic        pad_read,
    input  logic        pad_write,
    input  logic [31:0] pad_data_in,
    output logic [31:0] pad_data_out,
    output logic        pad_data_valid,
    input  logic        clear_error,
    output logic        bus_error,
    output logic [31:0] error_address
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic {S_EMPTY, S_ARMED} state_t;

    state_t        r_state, w_state_next;
    logic [31:0]   r_addr;
    logic [1:0]    r_size;
    logic          r_legal;
    logic [31:0]   r_prefetch;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_new_in_range, w_new_aligned, w_new_legal;
    logic [AW-1:0] w_new_idx, w_cur_idx;
    logic [4:0]    w_lane_shift;
    logic [31:0]   w_rd_shifted, w_rd_masked, w_wr_shifted, w_merged;
    logic [3:0]    w_be;
    logic          w_access_ok, w_do_read, w_do_write, w_illegal;

    // BASE_ADDR is aligned to the memory size, so a range check is a compare of the upper bits.
    assign w_new_in_range = (pad_address[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign w_new_idx      = pad_address[AW+1:2];
    assign w_cur_idx      = r_addr[AW+1:2];
    assign w_lane_shift   = {r_addr[1:0], 3'b000};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_new_aligned = 1'b0;
        case (pad_data_size)
            SZ_BYTE: w_new_aligned = 1'b1;
            SZ_HALF: w_new_aligned = ~pad_address[0];
            SZ_WORD: w_new_aligned = (pad_address[1:0] == 2'b00);
            default: w_new_aligned = 1'b0;
        endcase
    end

    assign w_new_legal = w_new_in_range && w_new_aligned;

    // A read and a write strobed together are a protocol error, even when the address is legal.
    assign w_access_ok = (r_state == S_ARMED) && r_legal && !(pad_read && pad_write);
    assign w_do_read   = pad_read  && w_access_ok;
    assign w_do_write  = pad_write && w_access_ok;
    assign w_illegal   = (pad_read || pad_write) && !w_access_ok;

    assign w_rd_shifted = r_prefetch >> w_lane_shift;
    assign w_wr_shifted = pad_data_in << w_lane_shift;

    always_comb begin
        w_be        = 4'b0000;
        w_rd_masked = 32'h0;
        case (r_size)
            SZ_BYTE: begin
                w_be        = 4'b0001 << r_addr[1:0];
                w_rd_masked = {24'h0, w_rd_shifted[7:0]};
            end
            SZ_HALF: begin
                w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
                w_rd_masked = {16'h0, w_rd_shifted[15:0]};
            end
            SZ_WORD: begin
                w_be        = 4'b1111;
                w_rd_masked = w_rd_shifted;
            end
            default: begin
                w_be        = 4'b0000;
                w_rd_masked = 32'h0;
            end
        endcase
    end

    always_comb begin
        w_merged = r_prefetch;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) w_merged[8*i +: 8] = w_wr_shifted[8*i +: 8];
        end
    end

    assign pad_data_valid = w_do_read;
    assign pad_data_out   = w_do_read ? w_rd_masked : 32'h0;

    always_comb begin
        w_state_next = r_state;
        if (pad_write_address)        w_state_next = S_ARMED;
        else if (pad_read || pad_write) w_state_next = S_EMPTY;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state    <= S_EMPTY;
            r_addr     <= 32'h0;
            r_size     <= 2'b00;
            r_legal    <= 1'b0;
            r_prefetch <= 32'h0;
        end else begin
            r_state <= w_state_next;
            if (pad_write_address) begin
                r_addr  <= pad_address;
                r_size  <= pad_data_size;
                r_legal <= w_new_legal;
                // A write that closes at this edge to the word being relatched must bypass the stale RAM read.
                r_prefetch <= (w_do_write && (w_new_idx == w_cur_idx)) ? w_merged : r_mem[w_new_idx];
            end else if (w_do_write) begin
                r_prefetch <= w_merged;
            end
        end
    end

    // NOTE: the RAM array has no reset; only its control path does, so it maps onto block memory.
    always_ff @(posedge clock) begin
        if (w_do_write) r_mem[w_cur_idx] <= w_merged;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_error     <= 1'b0;
            error_address <= 32'h0;
        end else if (w_illegal) begin
            bus_error     <= 1'b1;
            error_address <= (r_state == S_EMPTY) ? 32'h0 : r_addr;
        end else if (clear_error) begin
            bus_error <= 1'b0;
        end
    end

endmodule
